gppcu_fpu_arbiter: RTL
======================

GPPCU_FPU_ARBITER -- requirements
Module: GPPCU_FPU_ARBITER

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 4: number of requesting threads, range 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before abort, range 2..1024.
REQ-003 SHALL have port iACLK, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port inRST, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port iREQ, input, NUM_THREADS: per-thread FPU request level.
REQ-006 SHALL have port iREQ_OPC, input, 3*NUM_THREADS: per-thread FPU opcode, thread i at bits [3i+:3].
REQ-007 SHALL have port iREQ_DA, input, 32*NUM_THREADS: per-thread operand A, thread i at bits [32i+:32].
REQ-008 SHALL have port iREQ_DB, input, 32*NUM_THREADS: per-thread operand B, thread i at bits [32i+:32].
REQ-009 SHALL have port oDONE, output, NUM_THREADS: one-cycle completion pulse for the served thread.
REQ-010 SHALL have port oERR, output, 1: one-cycle timeout flag, coincident with oDONE.
REQ-011 SHALL have port oRESULT, output, 32: result for the thread pulsed on oDONE.
REQ-012 SHALL have port oBUSY, output, NUM_THREADS: bit i high while thread i requests and is not yet done, for the stall logic.
REQ-013 SHALL have port oFPU_START, output, 1: start pulse to the multicycle FPU.
REQ-014 SHALL have port oFPU_DA, output, 32: FPU operand A.
REQ-015 SHALL have port oFPU_DB, output, 32: FPU operand B.
REQ-016 SHALL have port oFPU_N, output, 3: FPU opcode.
REQ-017 SHALL have port iFPU_DONE, input, 1: FPU completion.
REQ-018 SHALL have port iFPU_RESULT, input, 32: FPU result, valid with iFPU_DONE.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE: if any iREQ bit is set, SHALL grant one thread by round-robin, latch its opcode and operands into oFPU_N/DA/DB, latch its ID, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-021 Round-robin: the search SHALL start at pointer P and go upward with wrap-around; after each grant P SHALL become (granted ID + 1) mod NUM_THREADS.
REQ-022 ISSUE: oFPU_START SHALL be high for exactly this one cycle; the timeout counter SHALL clear; next state WAIT.
REQ-023 WAIT: on iFPU_DONE, SHALL register iFPU_RESULT into oRESULT and go to DONE with oERR=0.
REQ-024 WAIT: without iFPU_DONE, the counter SHALL increment; when it reaches TIMEOUT_CYCLES-1, SHALL go to DONE with oRESULT=0 and oERR=1.
REQ-025 DONE: oDONE[granted ID] SHALL be high for exactly this cycle, with oERR as decided in WAIT; next state IDLE.
REQ-026 iREQ SHALL NOT be sampled in ISSUE, WAIT or DONE; the latched operands SHALL hold from grant until the next grant.
REQ-027 A request deasserted mid-operation SHALL NOT abort it; oDONE SHALL still pulse for that thread.
REQ-028 iFPU_DONE outside WAIT SHALL be ignored.
REQ-029 iFPU_DONE in the same cycle the counter reaches its limit SHALL count as success (oERR=0).
REQ-030 oBUSY[i] SHALL equal iREQ[i] AND NOT oDONE[i] (combinational).
REQ-031 Minimum latency SHALL be 4 cycles from a request sampled in IDLE to oDONE, with the FPU answering on the first WAIT cycle.
REQ-032 Throughput SHALL be at most one operation per 4 cycles.
REQ-033 A requester SHALL drop iREQ on the edge after it sees oDONE; otherwise it is re-granted as a new request.

Reset
REQ-034 While inRST=0, asynchronously: state=IDLE, P=0, counter=0, granted ID=0.
REQ-035 While inRST=0, asynchronously: oDONE=0, oERR=0, oFPU_START=0, oRESULT=0, oFPU_DA=0, oFPU_DB=0, oFPU_N=0.
REQ-036 Reset asserted mid-operation SHALL abandon the operation with no oDONE pulse.
REQ-037 After reset release, a late iFPU_DONE SHALL be ignored.

Verification
REQ-038 Single request: iREQ=4'b0001, DA=0x3F800000, DB=0x40000000, OPC=0; FPU answers 0x40400000 after 5 cycles -> oFPU_START pulses once; oDONE=4'b0001 for one cycle; oRESULT=0x40400000; oERR=0.
REQ-039 Round-robin fairness: iREQ=4'b1111 held, each thread dropping after its done -> grant order 0,1,2,3, one oDONE pulse per thread.
REQ-040 Wrap: P=3 after serving thread 2, then iREQ=4'b1001 -> thread 3 is served before thread 0.
REQ-041 Timeout: FPU never asserts done, TIMEOUT_CYCLES=64 -> oDONE and oERR high together 64 WAIT cycles after ISSUE; oRESULT=0; the next request is served normally.
REQ-042 Reset in WAIT: inRST low for 2 cycles, then iFPU_DONE pulses -> no oDONE; all outputs 0; P=0.
REQ-043 Deassert mid-operation: thread 2's iREQ drops in WAIT -> oDONE[2] still pulses with the FPU result.

Source files
------------

// File: rtl/gppcu_fpu_arbiter.sv
// Round-robin arbiter that shares one multicycle FPU among NUM_THREADS requesters.
// One operation in flight at a time: IDLE -> ISSUE -> WAIT -> DONE, with WAIT bounded by a timeout.
module gppcu_fpu_arbiter #(
   parameter int NUM_THREADS    = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                        iACLK,
   input  logic                        inRST,
   input  logic [NUM_THREADS-1:0]      iREQ,
   input  logic [3*NUM_THREADS-1:0]    iREQ_OPC,
   input  logic [32*NUM_THREADS-1:0]   iREQ_DA,
   input  logic [32*NUM_THREADS-1:0]   iREQ_DB,
   output logic [NUM_THREADS-1:0]      oDONE,
   output logic                        oERR,
   output logic [31:0]                 oRESULT,
   output logic [NUM_THREADS-1:0]      oBUSY,
   output logic                        oFPU_START,
   output logic [31:0]                 oFPU_DA,
   output logic [31:0]                 oFPU_DB,
   output logic [2:0]                  oFPU_N,
   input  logic                        iFPU_DONE,
   input  logic [31:0]                 iFPU_RESULT
);
   localparam int PW = $clog2(NUM_THREADS);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, gnt_q, pick, idx, ptr_nxt;
   logic [TW-1:0]   cnt_q;
   logic            any_req, err_q, cnt_lim;

   // Search upward from the pointer; iterating downward lets the nearest requester win.
   always_comb begin
      pick    = '0;
      idx     = '0;
      any_req = 1'b0;
      for (int k = NUM_THREADS-1; k >= 0; k--) begin
         idx = PW'((int'(ptr_q) + k) % NUM_THREADS);
         if (iREQ[idx]) begin
            pick    = idx;
            any_req = 1'b1;
         end
      end
   end

   assign ptr_nxt = (pick == PW'(NUM_THREADS-1)) ? '0 : pick + PW'(1);
   assign cnt_lim = (cnt_q == TW'(TIMEOUT_CYCLES-1));

   always_ff @(posedge iACLK or negedge inRST) begin
      if (!inRST) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_req) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (iFPU_DONE || cnt_lim) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iACLK or negedge inRST) begin
      if (!inRST) begin
         ptr_q   <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         oRESULT <= '0;
         oFPU_DA <= '0;
         oFPU_DB <= '0;
         oFPU_N  <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (any_req) begin
               gnt_q   <= pick;
               ptr_q   <= ptr_nxt;
               oFPU_N  <= iREQ_OPC[3*int'(pick) +: 3];
               oFPU_DA <= iREQ_DA[32*int'(pick) +: 32];
               oFPU_DB <= iREQ_DB[32*int'(pick) +: 32];
            end
            S_ISSUE: cnt_q <= '0;
            S_WAIT: begin
               // A completion on the limit cycle still wins over the timeout.
               if (iFPU_DONE) begin
                  oRESULT <= iFPU_RESULT;
                  err_q   <= 1'b0;
               end else if (cnt_lim) begin
                  oRESULT <= '0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign oFPU_START = (state_q == S_ISSUE);
   assign oERR       = (state_q == S_DONE) && err_q;

   for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thr
      assign oDONE[i] = (state_q == S_DONE) && (gnt_q == PW'(i));
   end

   assign oBUSY = iREQ & ~oDONE;
endmodule
